if_prefetch: RTL and testbench

Instruction-fetch front end for the 5-stage pipelined datapath. It sits directly upstream of the IF/ID pipeline buffer and replaces the bare PC / PC+4 / instruction-memory path. It issues one outstanding request at a time to a handshaked instruction memory and buffers fetched words with their PC+4 in a small FIFO. It presents them to decode with a valid/ready handshake and flushes on branch/jump redirects from the MEM stage.

---
 rtl/if_prefetch.sv | 181 ++++++++++++++++++
 tb/tb_if_prefetch.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - instruction-fetch prefetch front end with redirect flush
//
// Issues one outstanding request at a time to a handshaked instruction memory.
// Fetched words are buffered together with their PC+4 in a DEPTH-entry FIFO and
// handed to decode through a valid/ready handshake. A Redirect from the MEM stage
// flushes the FIFO and restarts fetching at the new address.
//
// Optional feature: define IFP_STATS_EN to add the StallCnt output.
//
// Ports:
//   Clk, Rst_n           clock (rising edge), asynchronous active-low reset
//   Redirect, RedirectPC taken branch/jump and its target (bits [1:0] ignored)
//   MemReq, MemAddr      instruction-memory request and its address
//   MemAck, MemRdata     request completion and returned instruction word
//   IfValid, IfReady     head-entry handshake towards decode
//   IfInstr, IfPCnext    head instruction and its PC+4
//   StallCnt             (IFP_STATS_EN only) saturating count of starved cycles
module if_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  input  logic [31:0] MemRdata,
  output logic        IfValid,
  input  logic        IfReady,
  output logic [31:0] IfInstr,
  output logic [31:0] IfPCnext
`ifdef IFP_STATS_EN
  ,
  output logic [31:0] StallCnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t        r_state;
  logic          r_mem_req;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_fetch_pc;

  logic [31:0]   r_instr  [DEPTH];
  logic [31:0]   r_pcnext [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_next;
  logic [31:0]   w_pc_plus4;
  logic [31:0]   w_redirect_pc;

  assign w_pc_plus4    = r_fetch_pc + 32'd4;
  assign w_redirect_pc = RedirectPC & 32'hFFFF_FFFC;

  // Only an ack to a live FETCH request carries useful data; DRAIN acks are stale.
  assign w_push       = (r_state == S_FETCH) && MemAck && !Redirect;
  assign w_pop        = IfValid && IfReady;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  assign IfValid  = (r_count != '0) && !Redirect;
  assign IfInstr  = r_instr[r_rd_ptr];
  assign IfPCnext = r_pcnext[r_rd_ptr];
  assign MemReq   = r_mem_req;
  assign MemAddr  = r_mem_addr;

  // Request FSM. r_mem_addr only moves when no request is outstanding or when the
  // outstanding one is acked this cycle, so the address is stable until its ack.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else if (Redirect) begin
      r_fetch_pc <= w_redirect_pc;
      if (r_state == S_IDLE || MemAck) begin
        // Nothing left in flight: restart immediately at the target. A DRAIN
        // whose stale ack lands with a new Redirect also ends here.
        r_state    <= S_FETCH;
        r_mem_req  <= 1'b1;
        r_mem_addr <= w_redirect_pc;
      end else begin
        // Request still in flight: keep it up with its old address until acked.
        r_state   <= S_DRAIN;
        r_mem_req <= 1'b1;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_count < FULL_CNT) begin
            r_state    <= S_FETCH;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
          end
        end
        S_FETCH: begin
          if (MemAck) begin
            r_fetch_pc <= w_pc_plus4;
            r_mem_addr <= w_pc_plus4;
            if (w_count_next < FULL_CNT) begin
              r_state   <= S_FETCH;
              r_mem_req <= 1'b1;
            end else begin
              r_state   <= S_IDLE;
              r_mem_req <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (MemAck) begin
            r_state    <= S_FETCH;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage; a Redirect empties it and blocks the same-cycle push and pop.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i]  <= 32'h0;
        r_pcnext[i] <= 32'h0;
      end
    end else if (Redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_instr[r_wr_ptr]  <= MemRdata;
        r_pcnext[r_wr_ptr] <= w_pc_plus4;
        r_wr_ptr           <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
    end
  end

`ifdef IFP_STATS_EN
  logic [31:0] r_stall_cnt;

  // Cycles where decode could take an instruction but none is available.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_stall_cnt <= 32'h0;
    end else if (IfReady && !IfValid && !Redirect && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign StallCnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// tb/tb_if_prefetch.sv - self-checking bench for if_prefetch
module tb_if_prefetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic [31:0] MemRdata;
  logic        IfValid;
  logic        IfReady;
  logic [31:0] IfInstr;
  logic [31:0] IfPCnext;
`ifdef IFP_STATS_EN
  logic [31:0] StallCnt;
`endif

  int          total   = 0;
  int          bad     = 0;
  int          ack_cnt = 0;
  logic [31:0] exp_pc;
  logic [3:0]  mem_lat;
  logic [3:0]  wait_cnt;

  always #5 Clk = ~Clk;

  if_prefetch #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .MemReq     (MemReq),
    .MemAddr    (MemAddr),
    .MemAck     (MemAck),
    .MemRdata   (MemRdata),
    .IfValid    (IfValid),
    .IfReady    (IfReady),
    .IfInstr    (IfInstr),
    .IfPCnext   (IfPCnext)
`ifdef IFP_STATS_EN
    ,
    .StallCnt   (StallCnt)
`endif
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory: acks once the request has waited mem_lat cycles.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) wait_cnt <= 4'd0;
    else if (MemReq && !MemAck) wait_cnt <= wait_cnt + 4'd1;
    else wait_cnt <= 4'd0;
  end
  assign MemAck   = MemReq && (wait_cnt >= mem_lat);
  assign MemRdata = memf(MemAddr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic mid();
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Rst_n   = 1'b0;
    ack_cnt = 0;
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
  endtask

  // Reference: the delivered stream is sequential words from the last restart
  // address (reset or redirect target), each tagged with its own address + 4.
  task automatic monitor();
    logic        prev_pend;
    logic [31:0] prev_addr;
    prev_pend = 1'b0;
    prev_addr = 32'h0;
    forever begin
      @(negedge Clk);
      if (!Rst_n) begin
        exp_pc    = RESET_PC;
        prev_pend = 1'b0;
        continue;
      end
      if (prev_pend) begin
        check("m_req_hold", MemReq, 1);
        check("m_addr_hold", MemAddr, prev_addr);
      end
      if (Redirect) check("m_valid_in_redirect", IfValid, 0);
      if (IfValid && IfReady) begin
        check("m_instr", IfInstr, memf(exp_pc));
        check("m_pcnext", IfPCnext, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
      end
      if (Redirect) exp_pc = RedirectPC & 32'hFFFF_FFFC;
      if (MemReq && MemAck) ack_cnt++;
      prev_pend = MemReq && !MemAck;
      prev_addr = MemAddr;
    end
  endtask

  initial begin
    int n;
    Rst_n      = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = 32'h0;
    IfReady    = 1'b1;
    mem_lat    = 4'd0;
    exp_pc     = RESET_PC;
    fork
      monitor();
    join_none

    // Reset values
    repeat (2) @(posedge Clk);
    mid();
    check("rst_memreq", MemReq, 0);
    check("rst_memaddr", MemAddr, RESET_PC);
    check("rst_ifvalid", IfValid, 0);
    check("rst_ifinstr", IfInstr, 0);
    check("rst_ifpcnext", IfPCnext, 0);

    // Zero-wait memory, IfReady=1: one instruction per cycle
    next_cycle();
    Rst_n = 1'b1;
    next_cycle(); mid();
    check("t1_first_req", MemReq, 1);
    check("t1_first_addr", MemAddr, 32'h0);
    check("t1_c1_valid", IfValid, 0);
    for (int k = 2; k < 10; k++) begin
      next_cycle(); mid();
      check("t1_addr", MemAddr, 32'(4 * (k - 1)));
      check("t1_valid", IfValid, 1);
      check("t1_pcnext", IfPCnext, 32'(4 * (k - 1)));
    end

    // IfReady=0: exactly DEPTH acks then idle; drain with concurrent refetch
    next_cycle();
    IfReady = 1'b0;
    do_reset();
    repeat (10) next_cycle();
    mid();
    check("t2_ack_count", 32'(ack_cnt), 4);
    check("t2_req_idle", MemReq, 0);
    check("t2_valid_full", IfValid, 1);
    next_cycle();
    IfReady = 1'b1;
    mid();
    check("t2_head_instr", IfInstr, memf(32'h0));
    check("t2_head_pcnext", IfPCnext, 32'h4);
    next_cycle(); mid();
    check("t2_still_idle", MemReq, 0);
    check("t2_pcnext1", IfPCnext, 32'h8);
    next_cycle(); mid();
    check("t2_resume_req", MemReq, 1);
    check("t2_resume_addr", MemAddr, 32'h10);
    check("t2_pcnext2", IfPCnext, 32'hC);
    repeat (8) next_cycle();

    // Redirect with ack, pop attempt and three entries held
    IfReady = 1'b0;
    do_reset();
    repeat (4) next_cycle();
    IfReady    = 1'b1;
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0200;
    mid();
    check("t4_ack_coincident", MemAck, 1);
    check("t4_valid_redirect", IfValid, 0);
    next_cycle();
    Redirect = 1'b0;
    mid();
    check("t4_empty", IfValid, 0);
    check("t4_new_addr", MemAddr, 32'h0000_0200);
    check("t4_new_req", MemReq, 1);
    next_cycle(); mid();
    check("t4_first_valid", IfValid, 1);
    check("t4_first_pcnext", IfPCnext, 32'h0000_0204);
    check("t4_first_instr", IfInstr, memf(32'h0000_0200));

    // Redirect to an unaligned address at the top of memory: wraps to 0
    repeat (2) next_cycle();
    Redirect   = 1'b1;
    RedirectPC = 32'hFFFF_FFFE;
    next_cycle();
    Redirect = 1'b0;
    mid();
    check("t5_addr_top", MemAddr, 32'hFFFF_FFFC);
    next_cycle(); mid();
    check("t5_addr_wrap", MemAddr, 32'h0);
    check("t5_valid", IfValid, 1);
    check("t5_pcnext_wrap", IfPCnext, 32'h0);
    check("t5_instr_top", IfInstr, memf(32'hFFFF_FFFC));
    next_cycle(); mid();
    check("t5_pcnext_next", IfPCnext, 32'h4);

    // Reset while a request is outstanding
    next_cycle();
    mem_lat = 4'd3;
    next_cycle();
    check("rm_pending", MemReq && !MemAck, 1);
    Rst_n = 1'b0;
    #1;
    check("rm_memreq", MemReq, 0);
    check("rm_ifvalid", IfValid, 0);
    check("rm_memaddr", MemAddr, RESET_PC);

    // 3-cycle memory, Redirect in the second wait cycle
    ack_cnt = 0;
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    next_cycle();
    next_cycle();
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0100;
    mid();
    check("t3_no_ack_yet", MemAck, 0);
    next_cycle();
    Redirect = 1'b0;
    mid();
    check("t3_drain_req", MemReq, 1);
    check("t3_drain_addr", MemAddr, 32'h0);
    check("t3_drain_valid", IfValid, 0);
    next_cycle(); mid();
    check("t3_stale_ack", MemAck, 1);
    check("t3_stale_addr", MemAddr, 32'h0);
    next_cycle(); mid();
    check("t3_new_addr", MemAddr, 32'h0000_0100);
    check("t3_new_req", MemReq, 1);
    n = 0;
    while (!IfValid && n < 20) begin
      next_cycle(); mid();
      n++;
    end
    check("t3_valid_latency", 32'(n), 4);
    check("t3_first_pcnext", IfPCnext, 32'h0000_0104);
    check("t3_first_instr", IfInstr, memf(32'h0000_0100));

`ifdef IFP_STATS_EN
    // Stall counter: 5 starved cycles with IfReady=1, then 2 with IfReady=0
    next_cycle();
    IfReady = 1'b0;
    mem_lat = 4'd15;
    do_reset();
    next_cycle();
    IfReady = 1'b1;
    repeat (5) next_cycle();
    IfReady = 1'b0;
    next_cycle();
    next_cycle(); mid();
    check("st_count", StallCnt, 32'd5);
    check("st_req_pending", MemReq, 1);
    next_cycle();
    Rst_n = 1'b0;
    #1;
    check("st_reset_cnt", StallCnt, 32'd0);
    check("st_reset_req", MemReq, 0);
    repeat (2) @(posedge Clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
